// File: rtl/flash_sample_fetch.sv
// -----------------------------------------------------------------------------
// flash_sample_fetch
//
// Purpose:
//   Fetches 32-bit words from flash through an Avalon-MM read master and
//   plays them out as two 16-bit audio samples, one per sample_tick. The word
//   address walks forward or backward through the song and wraps at both
//   ends. The handshake back to the keyboard FSM is start_read/dir/restart in
//   and readFinish/dataReady out.
//
// Ports:
//   clk                 system clock (50 MHz)
//   reset_n             asynchronous active-low reset
//   sample_tick         one-cycle audio-rate strobe (synchronous to clk)
//   start_read          level: 1 = play, 0 = pause
//   dir                 level: 0 = forward, 1 = backward
//   restart             level: jump to song start for dir (sampled only when
//                       a new word fetch begins)
//   readFinish          one-cycle pulse after a flash word is captured
//   dataReady           1 while no flash transaction is outstanding
//   flash_read          Avalon read request
//   flash_address       Avalon word address
//   flash_waitrequest   Avalon waitrequest
//   flash_readdata      Avalon read data
//   flash_readdatavalid Avalon read data valid
//   audio_sample        current sample, held between updates
//   sample_valid        one-cycle pulse when audio_sample updates
//   timeout_err         sticky read-timeout flag
//
// Build option:
//   FLASH_READ_TIMEOUT_EN  when defined, a read that gets no readdatavalid
//                          within TIMEOUT_CYC cycles is completed with a zero
//                          word (silence) and timeout_err is set until reset.
//                          When undefined the FSM waits indefinitely and
//                          timeout_err is tied low.
// -----------------------------------------------------------------------------
module flash_sample_fetch #(
  parameter int                ADDR_W      = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = 23'h7FFFF,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic              start_read,
  input  logic              dir,
  input  logic              restart,
  output logic              readFinish,
  output logic              dataReady,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       audio_sample,
  output logic              sample_valid,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_SEND_FIRST,
    ST_WAIT_TICK2,
    ST_SEND_SECOND,
    ST_ADVANCE
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] address_reg;
  logic              dir_q_reg;
  logic [31:0]       word_reg;
  logic [15:0]       audio_sample_reg;
  logic              sample_valid_reg;
  logic              read_finish_reg;
  logic              flash_read_reg;
  logic              data_ready_reg;

  // Both the playback start and the mid-word resume are gated the same way.
  logic              play_tick;
  assign play_tick = sample_tick & start_read;

  // Next word address for the direction latched at the start of this word.
  logic [ADDR_W-1:0] address_step;
  always_comb begin
    address_step = address_reg;
    if (dir_q_reg) begin
      address_step = (address_reg == '0) ? MAX_ADDR : address_reg - 1'b1;
    end else begin
      address_step = (address_reg == MAX_ADDR) ? '0 : address_reg + 1'b1;
    end
  end

`ifdef FLASH_READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timeout_cnt_reg;
  logic          timeout_err_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      address_reg      <= '0;
      dir_q_reg        <= 1'b0;
      word_reg         <= '0;
      audio_sample_reg <= '0;
      sample_valid_reg <= 1'b0;
      read_finish_reg  <= 1'b0;
      flash_read_reg   <= 1'b0;
      data_ready_reg   <= 1'b1;
`ifdef FLASH_READ_TIMEOUT_EN
      timeout_cnt_reg  <= '0;
      timeout_err_reg  <= 1'b0;
`endif
    end else begin
      // Pulses default low; each is raised for exactly one state visit.
      read_finish_reg  <= 1'b0;
      sample_valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (play_tick) begin
            dir_q_reg <= dir;
            if (restart) begin
              address_reg <= dir ? MAX_ADDR : '0;
            end
            flash_read_reg <= 1'b1;
            data_ready_reg <= 1'b0;
            state_reg      <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (!flash_waitrequest) begin
            flash_read_reg <= 1'b0;
            state_reg      <= ST_WAIT_DATA;
`ifdef FLASH_READ_TIMEOUT_EN
            timeout_cnt_reg <= '0;
`endif
          end
        end

        // start_read is deliberately ignored here: a read in flight always
        // completes so the flash controller never sees an abandoned request.
        ST_WAIT_DATA: begin
          if (flash_readdatavalid) begin
            word_reg        <= flash_readdata;
            read_finish_reg <= 1'b1;
            data_ready_reg  <= 1'b1;
            state_reg       <= ST_SEND_FIRST;
          end
`ifdef FLASH_READ_TIMEOUT_EN
          else if (timeout_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
            // Give up on the controller and play silence for this word.
            word_reg        <= '0;
            read_finish_reg <= 1'b1;
            data_ready_reg  <= 1'b1;
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_SEND_FIRST;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
`endif
        end

        // Backward playback reverses the sample order inside each word too.
        ST_SEND_FIRST: begin
          audio_sample_reg <= dir_q_reg ? word_reg[31:16] : word_reg[15:0];
          sample_valid_reg <= 1'b1;
          state_reg        <= ST_WAIT_TICK2;
        end

        ST_WAIT_TICK2: begin
          if (play_tick) begin
            state_reg <= ST_SEND_SECOND;
          end
        end

        ST_SEND_SECOND: begin
          audio_sample_reg <= dir_q_reg ? word_reg[15:0] : word_reg[31:16];
          sample_valid_reg <= 1'b1;
          state_reg        <= ST_ADVANCE;
        end

        ST_ADVANCE: begin
          address_reg <= address_step;
          state_reg   <= ST_IDLE;
        end

        default: begin
          flash_read_reg <= 1'b0;
          data_ready_reg <= 1'b1;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

  assign readFinish    = read_finish_reg;
  assign dataReady     = data_ready_reg;
  assign flash_read    = flash_read_reg;
  assign flash_address = address_reg;
  assign audio_sample  = audio_sample_reg;
  assign sample_valid  = sample_valid_reg;

`ifdef FLASH_READ_TIMEOUT_EN
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_flash_sample_fetch.sv
// -----------------------------------------------------------------------------
// tb_flash_sample_fetch
//
// Purpose:
//   Self-checking bench for flash_sample_fetch. A flash responder serves words
//   from a fixed address->data function with programmable waitrequest and read
//   latency. A song-level model updated at every sample_tick predicts the
//   sequence of fetch addresses and audio samples; a per-cycle compare process
//   checks readFinish, dataReady, sample order and held audio against it, and
//   directed steps pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_flash_sample_fetch;

  localparam int          ADDR_W   = 23;
  localparam logic [22:0] MAX_ADDR = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        start_read = 1'b0;
  logic        dir = 1'b0;
  logic        restart = 1'b0;
  logic        flash_waitrequest = 1'b0;
  logic [31:0] flash_readdata = '0;
  logic        flash_readdatavalid = 1'b0;
  logic        readFinish, dataReady, flash_read, sample_valid, timeout_err;
  logic [22:0] flash_address;
  logic [15:0] audio_sample;

  flash_sample_fetch #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
    .start_read(start_read), .dir(dir), .restart(restart),
    .readFinish(readFinish), .dataReady(dataReady),
    .flash_read(flash_read), .flash_address(flash_address),
    .flash_waitrequest(flash_waitrequest), .flash_readdata(flash_readdata),
    .flash_readdatavalid(flash_readdatavalid),
    .audio_sample(audio_sample), .sample_valid(sample_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Flash contents: address 0 holds the documented test word.
  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == 23'd0) return 32'hAAAA5555;
    return {a[15:0] ^ 16'h1234, a[15:0] ^ 16'hBEEF};
  endfunction

  function automatic logic [22:0] step(input logic [22:0] a, input bit d);
    if (d) return (a == 23'd0) ? MAX_ADDR : a - 23'd1;
    return (a == MAX_ADDR) ? 23'd0 : a + 23'd1;
  endfunction

  // ---------------- song-level model ----------------
  logic [22:0] m_addr = '0;
  bit          m_dir = 1'b0;
  bit          m_half = 1'b0;
  logic [22:0] exp_addr_q[$];
  logic [15:0] exp_smp_q[$];
  logic [15:0] cur_smp = '0;

  // ---------------- responder state ----------------
  int          wr_hold = 0;
  int          rd_lat = 1;
  int          wr_cnt = 0;
  int          lat_cnt = 0;
  bit          outstanding = 1'b0;
  bit          legit = 1'b0;
  bit          late_pulse = 1'b0;
  bit          withhold = 1'b0;
  logic [22:0] acc_addr = '0;
  logic [22:0] last_fetch = '0;
  bit          cmp_en = 1'b1;
  int          n_rf = 0;
  int          n_sv = 0;

  task automatic model_reset();
    exp_addr_q.delete();
    exp_smp_q.delete();
    cur_smp = '0; m_addr = '0; m_dir = 1'b0; m_half = 1'b0;
    outstanding = 1'b0; wr_cnt = 0; lat_cnt = 0; wr_hold = 0; rd_lat = 1;
  endtask

  // One audio tick; the model decides what this tick means for the song.
  task automatic tick(input int gap = 16);
    logic [31:0] w;
    @(negedge clk);
    sample_tick = 1'b1;
    if (start_read) begin
      if (m_half) begin
        m_half = 1'b0;
        m_addr = step(m_addr, m_dir);
      end else begin
        m_dir = dir;
        if (restart) m_addr = dir ? MAX_ADDR : 23'd0;
        w = mem_word(m_addr);
        exp_addr_q.push_back(m_addr);
        if (m_dir) begin exp_smp_q.push_back(w[31:16]); exp_smp_q.push_back(w[15:0]); end
        else       begin exp_smp_q.push_back(w[15:0]);  exp_smp_q.push_back(w[31:16]); end
        m_half = 1'b1;
      end
    end
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Flash responder: drives on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      legit = 1'b0;
      flash_readdatavalid = 1'b0;
      if (late_pulse) begin
        flash_readdatavalid = 1'b1;
        flash_readdata = 32'hDEADBEEF;
        late_pulse = 1'b0;
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0 && !withhold) begin
          flash_readdatavalid = 1'b1;
          flash_readdata = mem_word(acc_addr);
          legit = 1'b1;
          outstanding = 1'b0;
        end
      end
      if (flash_read === 1'b1) begin
        if (wr_cnt < wr_hold) begin
          flash_waitrequest = 1'b1;
          wr_cnt++;
        end else begin
          flash_waitrequest = 1'b0;
          wr_cnt = 0;
          acc_addr = flash_address;
          last_fetch = flash_address;
          outstanding = 1'b1;
          lat_cnt = rd_lat;
          if (exp_addr_q.size() == 0) begin
            checks++;
            $display("FAIL fetch_addr: unexpected fetch at %0h, expected none", flash_address);
          end else begin
            chk("fetch_addr", {9'd0, flash_address}, {9'd0, exp_addr_q.pop_front()});
          end
        end
      end else begin
        flash_waitrequest = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (readFinish === 1'b1) n_rf++;
      if (sample_valid === 1'b1) n_sv++;
      if (cmp_en) begin
        chk("readFinish", {31'd0, readFinish}, {31'd0, legit});
        chk("dataReady", {31'd0, dataReady}, {31'd0, !(flash_read || outstanding)});
        chk("no_overlap", {31'd0, readFinish & sample_valid}, 32'd0);
        if (sample_valid === 1'b1) begin
          if (exp_smp_q.size() == 0) begin
            checks++;
            $display("FAIL sample_order: unexpected sample %0h, expected none", audio_sample);
          end else begin
            cur_smp = exp_smp_q.pop_front();
          end
        end
        chk("audio_sample", {16'd0, audio_sample}, {16'd0, cur_smp});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int rf0, sv0, cyc;

  initial begin
    // ---- reset state ----
    #12;
    chk("rst_flash_read", {31'd0, flash_read}, 32'd0);
    chk("rst_dataReady", {31'd0, dataReady}, 32'd1);
    chk("rst_audio", {16'd0, audio_sample}, 32'd0);
    chk("rst_addr", {9'd0, flash_address}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- forward play from song start ----
    start_read = 1'b1; dir = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("fwd_addr0", {9'd0, last_fetch}, 32'd0);
    chk("fwd_first", {16'd0, audio_sample}, 32'h5555);
    tick();
    chk("fwd_second", {16'd0, audio_sample}, 32'hAAAA);
    tick();
    chk("fwd_addr1", {9'd0, last_fetch}, 32'd1);
    tick();
    for (int i = 2; i < 256; i++) begin
      tick();
      tick();
    end

    // ---- restart mid-word at 0x100 ----
    tick();
    chk("rs_addr100", {9'd0, last_fetch}, 32'h100);
    restart = 1'b1;
    rf0 = n_rf;
    tick();
    chk("rs_second_half", {16'd0, audio_sample}, 32'h1334);
    chk("rs_no_rf_yet", n_rf, rf0);
    tick();
    chk("rs_fetch0", {9'd0, last_fetch}, 32'd0);
    chk("rs_one_rf", n_rf, rf0 + 1);
    restart = 1'b0;
    tick();

    // ---- backward, wrap 0 -> MAX, dir change mid-word, forward MAX -> 0 ----
    dir = 1'b1;
    tick();
    chk("bk_addr1", {9'd0, last_fetch}, 32'd1);
    chk("bk_hi_first", {16'd0, audio_sample}, 32'h1235);
    tick();
    tick();
    chk("bk_addr0", {9'd0, last_fetch}, 32'd0);
    chk("bk_w0_hi", {16'd0, audio_sample}, 32'hAAAA);
    dir = 1'b0;
    tick();
    chk("dirchg_keeps_order", {16'd0, audio_sample}, 32'h5555);
    tick();
    chk("wrap_to_max", {9'd0, last_fetch}, {9'd0, MAX_ADDR});
    chk("fwd_max_lo", {16'd0, audio_sample}, 32'h4110);
    tick();
    tick();
    chk("fwd_max_to_0", {9'd0, last_fetch}, 32'd0);
    tick();

    // ---- backward restart ----
    dir = 1'b1; restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("bk_rs_max", {9'd0, last_fetch}, {9'd0, MAX_ADDR});
    chk("bk_rs_hi", {16'd0, audio_sample}, 32'hEDCB);
    tick();
    chk("bk_rs_lo", {16'd0, audio_sample}, 32'h4110);
    tick();
    chk("bk_next", {9'd0, last_fetch}, 32'h7FFFE);
    chk("bk_next_hi", {16'd0, audio_sample}, 32'hEDCA);
    tick();

    // ---- pause while the read is in flight ----
    wr_hold = 3; rd_lat = 2;
    rf0 = n_rf; sv0 = n_sv;
    tick(5);
    start_read = 1'b0;
    repeat (20) @(negedge clk);
    chk("pause_addr", {9'd0, last_fetch}, 32'h7FFFD);
    chk("pause_one_rf", n_rf, rf0 + 1);
    chk("pause_one_sv", n_sv, sv0 + 1);
    tick();
    tick();
    chk("pause_held", n_sv, sv0 + 1);
    chk("pause_audio_held", {16'd0, audio_sample}, 32'hEDC9);
    start_read = 1'b1;
    tick();
    chk("resume_sv", n_sv, sv0 + 2);
    chk("resume_lo", {16'd0, audio_sample}, 32'h4112);
    wr_hold = 0; rd_lat = 1;

    // ---- asynchronous reset during REQ ----
    wr_hold = 100;
    tick(2);
    @(posedge clk);
    chk("req_active", {31'd0, flash_read}, 32'd1);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_flash_read", {31'd0, flash_read}, 32'd0);
    chk("arst_dataReady", {31'd0, dataReady}, 32'd1);
    chk("arst_readFinish", {31'd0, readFinish}, 32'd0);
    chk("arst_sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("arst_audio", {16'd0, audio_sample}, 32'd0);
    chk("arst_addr", {9'd0, flash_address}, 32'd0);
    chk("arst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rf0 = n_rf;
    @(posedge clk);
    #2;
    late_pulse = 1'b1;
    repeat (5) @(negedge clk);
    chk("late_valid_ignored", n_rf, rf0);
    chk("late_still_idle", {31'd0, flash_read}, 32'd0);

`ifdef FLASH_READ_TIMEOUT_EN
    // ---- read timeout ----
    cmp_en = 1'b0;
    withhold = 1'b1;
    start_read = 1'b1; dir = 1'b0; restart = 1'b1;
    rf0 = n_rf;
    tick(1);
    restart = 1'b0;
    cyc = 0;
    while (n_rf == rf0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_rf_pulse", n_rf, rf0 + 1);
    repeat (3) @(negedge clk);
    chk("to_err_set", {31'd0, timeout_err}, 32'd1);
    chk("to_silence", {16'd0, audio_sample}, 32'd0);
    repeat (20) @(negedge clk);
    chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
    withhold = 1'b0;
`else
    chk("no_timeout_err", {31'd0, timeout_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
